// File: rtl/uart_loopback_fifo_if.sv
// Pin-level bundle for the UART echo block.
// Host side is master and the echo block is slave.
interface uart_loopback_fifo_if #(
  parameter int LW = 5
);
  logic          UART_RX;
  logic          UART_TX;
  logic          ECHO_EN;
  logic          CLR_ERR;
  logic          RX_OVERRUN;
  logic          FRAME_ERR;
  logic [LW-1:0] FIFO_LEVEL;

  modport master (
    output UART_RX, ECHO_EN, CLR_ERR,
    input  UART_TX, RX_OVERRUN, FRAME_ERR, FIFO_LEVEL
  );

  modport slave (
    input  UART_RX, ECHO_EN, CLR_ERR,
    output UART_TX, RX_OVERRUN, FRAME_ERR, FIFO_LEVEL
  );
endinterface

// File: rtl/uart_loopback_fifo.sv
// UART echo: oversampled receiver, byte FIFO and transmitter.
// Received bytes are buffered and echoed while ECHO_EN is high.
module uart_loopback_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 16
) (
  input  logic CLK,
  input  logic RST_N,
  uart_loopback_fifo_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  localparam logic [LW-1:0] LMAX = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } st_e;

  st_e rx_st_q, rx_st_d;
  st_e tx_st_q, tx_st_d;

  logic                 rx_s1_q, rx_s2_q;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 stop_smp;

  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_q, tx_d;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_q, rd_q;
  logic [LW-1:0]        lvl_q, lvl_d;
  logic                 ovr_q, ferr_q;
  logic                 push, pop, can_pop, full;
  logic                 ovr_ev, ferr_ev;

  assign full    = (lvl_q == LMAX);
  assign can_pop = bus.ECHO_EN && (lvl_q != '0);

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    stop_smp = 1'b0;
    unique case (rx_st_q)
      S_IDLE: begin
        if (!rx_s2_q) begin
          rx_st_d  = S_START;
          rx_cnt_d = '0;
          rx_bit_d = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF) begin
          rx_cnt_d = '0;
          rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == FULL) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == LAST) rx_st_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        // Back to IDLE on the sample so a start bit mid-stop is seen
        if (rx_cnt_q == FULL) begin
          stop_smp = 1'b1;
          rx_st_d  = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    pop      = 1'b0;
    unique case (tx_st_q)
      S_IDLE: begin
        if (can_pop) begin
          pop      = 1'b1;
          tx_sh_d  = mem_q[rd_q];
          tx_cnt_d = '0;
          tx_st_d  = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == FULL) begin
          tx_cnt_d = '0;
          tx_bit_d = '0;
          tx_st_d  = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == FULL) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b0, tx_sh_q[DATA_BITS-1:1]};
          tx_bit_d = tx_bit_q + 1'b1;
          if (tx_bit_q == LAST) tx_st_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        // Reload straight from STOP so bursts leave no idle gap
        if (tx_cnt_q == FULL) begin
          tx_cnt_d = '0;
          if (can_pop) begin
            pop     = 1'b1;
            tx_sh_d = mem_q[rd_q];
            tx_st_d = S_START;
          end else begin
            tx_st_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    if (tx_st_q == S_START) tx_d = 1'b0;
    if (tx_st_q == S_DATA)  tx_d = tx_sh_q[0];
  end

  assign push    = stop_smp && rx_s2_q && (!full || pop);
  assign ovr_ev  = stop_smp && rx_s2_q && full && !pop;
  assign ferr_ev = stop_smp && !rx_s2_q;

  always_comb begin
    lvl_d = lvl_q;
    unique case ({push, pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= rx_sh_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_st_q  <= S_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
      wr_q     <= '0;
      rd_q     <= '0;
      lvl_q    <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_s1_q  <= bus.UART_RX;
      rx_s2_q  <= rx_s1_q;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      tx_q     <= tx_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      lvl_q    <= lvl_d;
      ovr_q    <= ovr_ev  | (ovr_q  & ~bus.CLR_ERR);
      ferr_q   <= ferr_ev | (ferr_q & ~bus.CLR_ERR);
    end
  end

  assign bus.UART_TX    = tx_q;
  assign bus.RX_OVERRUN = ovr_q;
  assign bus.FRAME_ERR  = ferr_q;
  assign bus.FIFO_LEVEL = lvl_q;
endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Scoreboard bench for uart_loopback_fifo.
// A TX monitor decodes echoed frames against a queue of expected bytes.
module tb_uart_loopback_fifo;
  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int DEP = 4;
  localparam int LW  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_loopback_fifo_if #(.LW(LW)) bus ();

  uart_loopback_fifo #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(DB),
    .DEPTH(DEP)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] exp_q [$];
  bit gap_chk = 1'b0;
  int last_start = -1;
  bit mon_ab;
  logic [7:0] mon_d;
  logic mon_stop;
  int mon_st;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic mwait(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!rst_n) mon_ab = 1'b1;
    end
  endtask

  // TX monitor: decode a frame per start bit and score it
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !bus.UART_TX) begin
        mon_ab = 1'b0;
        mon_st = cyc;
        if (gap_chk && last_start >= 0)
          check("tx_gap", mon_st - last_start, 10 * CPB);
        last_start = gap_chk ? mon_st : -1;
        mwait(CPB / 2);
        for (int i = 0; i < DB; i++) begin
          mwait(CPB);
          mon_d[i] = bus.UART_TX;
        end
        mwait(CPB);
        mon_stop = bus.UART_TX;
        if (!mon_ab) begin
          check("tx_stop", mon_stop, 1);
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL tx_unexpected: got 0x%0h expected none", mon_d);
          end else begin
            check("tx_byte", mon_d, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_hi);
    @(negedge clk);
    bus.UART_RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      bus.UART_RX = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.UART_RX = stop_hi;
    repeat (CPB) @(negedge clk);
    bus.UART_RX = 1'b1;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++)
      @(negedge clk);
    check(nm, exp_q.size(), 0);
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.CLR_ERR = 1'b1;
    @(negedge clk);
    bus.CLR_ERR = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.UART_RX = 1'b1;
    bus.ECHO_EN = 1'b0;
    bus.CLR_ERR = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", bus.UART_TX, 1);
    check("rst_lvl", bus.FIFO_LEVEL, 0);
    check("rst_ovr", bus.RX_OVERRUN, 0);
    check("rst_ferr", bus.FRAME_ERR, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single echo and push-to-TX latency
    bus.ECHO_EN = 1'b1;
    exp_q.push_back(8'hA5);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 400 && bus.FIFO_LEVEL == 0; i++)
          @(negedge clk);
        check("s1_push_lvl", bus.FIFO_LEVEL, 1);
        check("s1_tx_n", bus.UART_TX, 1);
        @(negedge clk);
        check("s1_tx_n1", bus.UART_TX, 1);
        check("s1_lvl_n1", bus.FIFO_LEVEL, 0);
        @(negedge clk);
        check("s1_tx_n2", bus.UART_TX, 0);
      end
    join
    drain("s1_drain");
    check("s1_lvl", bus.FIFO_LEVEL, 0);
    check("s1_ovr", bus.RX_OVERRUN, 0);
    check("s1_ferr", bus.FRAME_ERR, 0);

    // 2: fill past full with echo held, then release burst
    bus.ECHO_EN = 1'b0;
    for (int v = 1; v <= 5; v++) send_byte(8'(v), 1'b1);
    for (int v = 1; v <= 4; v++) exp_q.push_back(8'(v));
    repeat (4) @(negedge clk);
    check("s2_lvl_full", bus.FIFO_LEVEL, 4);
    check("s2_ovr", bus.RX_OVERRUN, 1);
    gap_chk = 1'b1;
    bus.ECHO_EN = 1'b1;
    drain("s2_drain");
    gap_chk = 1'b0;
    check("s2_lvl_end", bus.FIFO_LEVEL, 0);
    check("s2_ovr_sticky", bus.RX_OVERRUN, 1);
    pulse_clr();
    check("s2_ovr_clr", bus.RX_OVERRUN, 0);

    // 3: framing error
    send_byte(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("s3_ferr", bus.FRAME_ERR, 1);
    check("s3_lvl", bus.FIFO_LEVEL, 0);
    check("s3_tx", bus.UART_TX, 1);
    check("s3_ovr", bus.RX_OVERRUN, 0);
    pulse_clr();
    check("s3_ferr_clr", bus.FRAME_ERR, 0);

    // 4: short glitch, then a real frame must still decode
    @(negedge clk);
    bus.UART_RX = 1'b0;
    repeat (4) @(negedge clk);
    bus.UART_RX = 1'b1;
    repeat (40) @(negedge clk);
    check("s4_lvl", bus.FIFO_LEVEL, 0);
    check("s4_ferr", bus.FRAME_ERR, 0);
    check("s4_ovr", bus.RX_OVERRUN, 0);
    check("s4_tx", bus.UART_TX, 1);
    exp_q.push_back(8'h66);
    send_byte(8'h66, 1'b1);
    drain("s4_drain");

    // 5: reset during TX data bit 3 of 0xFF
    fork
      send_byte(8'hFF, 1'b1);
      begin
        for (int i = 0; i < 400 && bus.UART_TX; i++) @(negedge clk);
        check("s5_tx_start", bus.UART_TX, 0);
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("s5_rst_tx", bus.UART_TX, 1);
        check("s5_rst_lvl", bus.FIFO_LEVEL, 0);
      end
    join
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check("s5_idle_tx", bus.UART_TX, 1);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    drain("s5_drain");

    // 6: push and pop in the same cycle while full
    bus.ECHO_EN = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    repeat (4) @(negedge clk);
    check("s6_lvl_full", bus.FIFO_LEVEL, 4);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    gap_chk = 1'b1;
    fork
      send_byte(8'h55, 1'b1);
      begin
        // start edge is driven at the first negedge; stop sample
        // lands on the posedge right after the 155th negedge
        repeat (155) @(negedge clk);
        bus.ECHO_EN = 1'b1;
        @(negedge clk);
        check("s6_lvl_same", bus.FIFO_LEVEL, 4);
        check("s6_ovr_same", bus.RX_OVERRUN, 0);
      end
    join
    drain("s6_drain");
    gap_chk = 1'b0;
    check("s6_lvl_end", bus.FIFO_LEVEL, 0);
    check("s6_ovr_end", bus.RX_OVERRUN, 0);
    check("final_q", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_loopback_fifo.md
Name: uart_loopback_fifo

Overview:
Parametrised UART echo block with its own oversampled receiver, a byte FIFO and a transmitter, all on one clock. Received frames are buffered so back-to-back input never corrupts output. ECHO_EN gates draining so the host can fill and release bursts. Overrun and framing errors are counted in sticky flags. Top-level use: between board UART pins and the core clock from the differential clock buffer.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4.
DATA_BITS, 8, payload bits per frame, LSB first, 5..9.
DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
CLK  in  1  system clock, all logic rising-edge.
RST_N  in  1  asynchronous active-low reset.
UART_RX  in  1  serial input, idle high, asynchronous to CLK.
UART_TX  out  1  serial output, idle high.
ECHO_EN  in  1  1 = TX drains FIFO; 0 = hold contents.
CLR_ERR  in  1  one-cycle pulse clears RX_OVERRUN and FRAME_ERR.
RX_OVERRUN  out  1  sticky: a frame arrived while FIFO full.
FRAME_ERR  out  1  sticky: stop bit sampled low.
FIFO_LEVEL  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH.

Behaviour:
- Reset (RST_N low, asynchronous): UART_TX=1, RX_OVERRUN=0, FRAME_ERR=0, FIFO_LEVEL=0, both FSMs in IDLE, RX synchroniser flops = 1. Reset mid-frame aborts both frames. Partial RX data is discarded. TX goes high immediately.
- RX input: 2-flop synchroniser, then edge logic on the synchronised signal only.
- RX FSM:
  - IDLE: synchronised RX low -> START, bit counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. Low -> DATA. High -> IDLE (glitch rejected, nothing pushed).
  - DATA: sample every CLKS_PER_BIT cycles, DATA_BITS samples, LSB first -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles. High and FIFO not full -> push. High and full -> drop, set RX_OVERRUN. Low -> drop, set FRAME_ERR. Always return to IDLE on the sample cycle, so the next start bit is detected mid-stop.
- FIFO: DEPTH entries x DATA_BITS, binary pointers wrapping mod DEPTH. Level is a separate counter.
  - Push on full with a pop in the same cycle: the push is accepted, level unchanged, no overrun.
  - Pop on empty never occurs.
- TX FSM, each bit held exactly CLKS_PER_BIT cycles:
  - IDLE: if ECHO_EN=1 and level>0, pop head into shift register -> START.
  - START: TX=0.
  - DATA: DATA_BITS bits, LSB first.
  - STOP: TX=1, one bit -> IDLE.
  - ECHO_EN falling mid-frame: the current frame completes and no further pop occurs.
- Latency: push registered at stop-sample cycle N. If TX idle and FIFO was empty, pop at N+1 and UART_TX falls at N+2.
- Error flags: set by an event, cleared by CLR_ERR. An event in the same cycle as CLR_ERR leaves the flag set.
- FIFO_LEVEL is registered and reflects push/pop of the previous cycle.

Test Plan:
Use CLKS_PER_BIT=16, DATA_BITS=8, DEPTH=4 for all scenarios.
1. Send 0xA5, ECHO_EN=1 -> TX frame 0xA5. UART_TX falls exactly 2 cycles after RX stop sample. FIFO_LEVEL ends 0, flags 0.
2. ECHO_EN=0, send 0x01..0x05 back-to-back -> FIFO_LEVEL=4, RX_OVERRUN=1. Set ECHO_EN=1 -> TX emits 0x01,0x02,0x03,0x04 with no gaps between frames. 0x05 is never sent.
3. Send frame 0x3C with stop bit forced low -> FRAME_ERR=1, FIFO_LEVEL stays 0, TX idle. Pulse CLR_ERR -> FRAME_ERR=0.
4. Drive a 4-cycle low glitch on UART_RX -> no push, no flags, RX FSM back in IDLE.
5. Assert RST_N low during the TX data bit 3 of 0xFF -> UART_TX=1 in the same cycle, FIFO_LEVEL=0. After release, send 0x5A -> correct echo.
6. Full FIFO with ECHO_EN=1, arrange an RX push in the same cycle as a TX pop -> FIFO_LEVEL stays 4, RX_OVERRUN=0, all bytes echoed in order.
